// File: rtl/uop_multi_queue.sv
// uop_multi_queue: multi-lane circular uop FIFO with NOP filtering, partial dequeue and flush
module uop_multi_queue #(
    parameter int DEPTH    = 32,
    parameter int IN_W     = 4,
    parameter int OUT_W    = 4,
    parameter int DROP_NOP = 1,
    parameter int UOP_BITS = 79,
    parameter int OPC_LSB  = 0,
    parameter int OPC_BITS = 8,
    parameter logic [OPC_BITS-1:0] UOP_NOP = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [IN_W-1:0]            in_valid,
    input  logic [IN_W*UOP_BITS-1:0]   in_uop,
    output logic                       in_ready,
    output logic [OUT_W-1:0]           out_valid,
    output logic [OUT_W*UOP_BITS-1:0]  out_uop,
    input  logic [$clog2(OUT_W+1)-1:0] out_pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       nop_dropped
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(OUT_W + 1);
    localparam int KW = $clog2(IN_W + 1);

    logic [UOP_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]       head, tail;
    logic [PW-1:0]       off [IN_W];
    logic [IN_W-1:0]     keep, is_nop;
    logic [KW-1:0]       kept;
    logic [OW-1:0]       avail, pop;
    logic                fire;

    assign in_ready = count <= CW'(DEPTH - IN_W);
    assign fire     = in_ready && |in_valid;
    assign empty    = count == '0;
    assign avail    = count >= CW'(OUT_W) ? OW'(OUT_W) : OW'(count);
    assign pop      = out_pop > avail ? avail : out_pop;

    // classify lanes and give each kept lane its slot offset from tail (compaction)
    always_comb begin
        kept   = '0;
        is_nop = '0;
        keep   = '0;
        off    = '{default: '0};
        for (int i = 0; i < IN_W; i++) begin
            is_nop[i] = in_uop[i*UOP_BITS+OPC_LSB +: OPC_BITS] == UOP_NOP;
            keep[i]   = in_valid[i] && !(DROP_NOP != 0 && is_nop[i]);
            off[i]    = PW'(kept);
            kept      = kept + KW'(keep[i]);
        end
    end

    // present the oldest entries; lanes past the valid range read as zero, never X
    always_comb begin
        out_valid = '0;
        out_uop   = '0;
        for (int j = 0; j < OUT_W; j++) begin
            out_valid[j] = CW'(j) < count;
            out_uop[j*UOP_BITS +: UOP_BITS] = out_valid[j] ? mem[head + PW'(j)] : '0;
        end
    end

    // pointers, occupancy and NOP-drop pulse; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            nop_dropped <= 1'b0;
        end else begin
            head        <= head + PW'(pop);
            tail        <= tail + (fire ? PW'(kept) : '0);
            count       <= count + (fire ? CW'(kept) : '0) - CW'(pop);
            nop_dropped <= fire && DROP_NOP != 0 && |(in_valid & is_nop);
        end
    end

    // write kept lanes into consecutive slots starting at tail
    always_ff @(posedge clk) begin
        if (fire && !rst && !flush)
            for (int i = 0; i < IN_W; i++)
                if (keep[i]) mem[tail + off[i]] <= in_uop[i*UOP_BITS +: UOP_BITS];
    end

    // popping more lanes than are valid is clamped, but signals a consumer bug
    assert property (@(posedge clk) disable iff (rst || flush) out_pop <= avail)
        else $warning("out_pop %0d exceeds valid lanes %0d; clamped", out_pop, avail);
endmodule

// File: tb/tb_uop_multi_queue.sv
// tb_uop_multi_queue: queue-model bench for uop_multi_queue with DROP_NOP=1 and DROP_NOP=0 instances
module tb_uop_multi_queue;
    localparam int DEPTH = 32;
    localparam int IN_W  = 4;
    localparam int OUT_W = 4;
    localparam int UB    = 79;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = $clog2(OUT_W + 1);
    localparam logic [7:0] NOP = 8'd0, ADD = 8'd1, SUB = 8'd2, AND_ = 8'd3, ORR = 8'd4, STORE = 8'd5;

    typedef logic [UB-1:0] uop_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic [IN_W-1:0]   in_valid = '0;
    logic [IN_W*UB-1:0] in_uop = '0;
    logic [OW-1:0]     out_pop = '0;
    logic              rdy [2];
    logic [OUT_W-1:0]  ov  [2];
    logic [OUT_W*UB-1:0] ou [2];
    logic [CW-1:0]     cnt [2];
    logic              emp [2];
    logic              nd  [2];

    uop_t mq [2][$];
    bit   mnop [2];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g
        uop_multi_queue #(
            .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .DROP_NOP(k == 0 ? 1 : 0),
            .UOP_BITS(UB), .OPC_LSB(0), .OPC_BITS(8), .UOP_NOP(NOP)
        ) dut (
            .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_uop(in_uop),
            .in_ready(rdy[k]), .out_valid(ov[k]), .out_uop(ou[k]), .out_pop(out_pop),
            .count(cnt[k]), .empty(emp[k]), .nop_dropped(nd[k])
        );
    end

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d] got=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic uop_t mk(input logic [7:0] op);
        uop_t u;
        u = uop_t'({$urandom(), $urandom(), $urandom()});
        u[7:0] = op;
        return u;
    endfunction

    // advance one clock: update the queue model from the sampled inputs, then compare
    task automatic step();
        int avail, pe, sz;
        bit fire, dropped;
        uop_t u;
        logic [OUT_W-1:0] ev;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst || flush) begin
                mq[k].delete();
                mnop[k] = 0;
            end else begin
                sz = mq[k].size();
                avail = sz < OUT_W ? sz : OUT_W;
                pe = int'(out_pop) < avail ? int'(out_pop) : avail;
                fire = (DEPTH - sz >= IN_W) && (in_valid != '0);
                dropped = 0;
                repeat (pe) void'(mq[k].pop_front());
                if (fire)
                    for (int i = 0; i < IN_W; i++)
                        if (in_valid[i]) begin
                            u = in_uop[i*UB +: UB];
                            if (k == 0 && u[7:0] == NOP) dropped = 1;
                            else mq[k].push_back(u);
                        end
                mnop[k] = dropped;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            sz = mq[k].size();
            ev = '0;
            for (int j = 0; j < OUT_W; j++) ev[j] = j < sz;
            chk("count", k, cnt[k], sz);
            chk("empty", k, emp[k], sz == 0);
            chk("in_ready", k, rdy[k], DEPTH - sz >= IN_W);
            chk("out_valid", k, ov[k], ev);
            chk("nop_dropped", k, nd[k], mnop[k]);
            for (int j = 0; j < OUT_W && j < sz; j++)
                chk("out_uop", k, ou[k][j*UB +: UB], mq[k][j]);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] ops, input int pop, input bit fl, input bit rs);
        in_valid = v;
        flush = fl;
        rst = rs;
        out_pop = OW'(pop);
        for (int i = 0; i < IN_W; i++) in_uop[i*UB +: UB] = mk(ops[i*8 +: 8]);
        step();
    endtask

    task automatic run_random(input int n);
        int m, ph, pop;
        logic [31:0] ops;
        for (int c = 0; c < n; c++) begin
            ph = (c / 400) % 3;
            m = mq[0].size() < mq[1].size() ? mq[0].size() : mq[1].size();
            if (m > OUT_W) m = OUT_W;
            for (int i = 0; i < IN_W; i++)
                ops[i*8 +: 8] = $urandom_range(0, 3) == 0 ? NOP : 8'($urandom_range(1, 5));
            pop = ph == 0 ? ($urandom_range(0, 3) == 0 ? $urandom_range(0, m) : 0)
                : ph == 1 ? m : $urandom_range(0, m);
            drive(4'($urandom()), ops, pop, $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
        end
    endtask

    initial begin
        logic [31:0] adds;
        adds = {ADD, ADD, ADD, ADD};
        drive(4'h0, 0, 0, 0, 1);
        chk("rst_count", 0, cnt[0], 0);
        chk("rst_ready", 0, rdy[0], 1);
        chk("rst_valid", 0, ov[0], 0);
        chk("rst_empty", 0, emp[0], 1);

        drive(4'hF, {ORR, AND_, SUB, ADD}, 0, 0, 0);
        chk("first_count", 0, cnt[0], 4);
        chk("first_valid", 0, ov[0], 4'b1111);
        chk("first_lane0", 0, ou[0][0 +: 8], ADD);
        chk("first_lane1", 0, ou[0][UB +: 8], SUB);
        chk("first_lane2", 0, ou[0][2*UB +: 8], AND_);
        chk("first_lane3", 0, ou[0][3*UB +: 8], ORR);
        chk("first_ready", 0, rdy[0], 1);

        repeat (6) drive(4'hF, adds, 0, 0, 0);
        drive(4'b0001, adds, 0, 0, 0);
        chk("full_count", 0, cnt[0], 29);
        chk("full_ready", 0, rdy[0], 0);
        drive(4'hF, adds, 0, 0, 0);
        chk("ignored_count", 0, cnt[0], 29);
        drive(4'h0, 0, 1, 0, 0);
        chk("pop1_count", 0, cnt[0], 28);
        chk("pop1_ready", 0, rdy[0], 1);

        drive(4'h0, 0, 0, 1, 0);
        drive(4'hF, {STORE, NOP, ADD, NOP}, 0, 0, 0);
        chk("nop_count", 0, cnt[0], 2);
        chk("nop_lane0", 0, ou[0][0 +: 8], ADD);
        chk("nop_lane1", 0, ou[0][UB +: 8], STORE);
        chk("nop_pulse", 0, nd[0], 1);
        chk("keep_count", 1, cnt[1], 4);
        chk("keep_pulse", 1, nd[1], 0);
        drive(4'h0, 0, 0, 0, 0);
        chk("nop_pulse_end", 0, nd[0], 0);

        drive(4'h0, 0, 0, 1, 0);
        drive(4'b0001, adds, 0, 0, 0);
        repeat (29) drive(4'b0001, adds, 1, 0, 0);
        drive(4'h0, 0, 1, 0, 0);
        chk("wrap_empty", 0, emp[0], 1);
        drive(4'hF, {STORE, ORR, AND_, SUB}, 0, 0, 0);
        chk("wrap_count", 0, cnt[0], 4);
        chk("wrap_lane0", 0, ou[0][0 +: 8], SUB);
        chk("wrap_lane1", 0, ou[0][UB +: 8], AND_);
        chk("wrap_lane2", 0, ou[0][2*UB +: 8], ORR);
        chk("wrap_lane3", 0, ou[0][3*UB +: 8], STORE);

        drive(4'h0, 0, 0, 1, 0);
        drive(4'hF, adds, 0, 0, 0);
        drive(4'b0011, adds, 0, 0, 0);
        drive(4'b0111, adds, 2, 0, 0);
        chk("simul_count", 0, cnt[0], 7);
        drive(4'h0, 0, 0, 1, 0);
        drive(4'b0011, adds, 0, 0, 0);
        drive(4'b0001, adds, 4, 0, 0);
        chk("clamp_count", 0, cnt[0], 1);

        drive(4'h0, 0, 0, 1, 0);
        drive(4'hF, adds, 0, 0, 0);
        drive(4'hF, adds, 0, 0, 0);
        drive(4'b0011, adds, 0, 0, 0);
        chk("pre_flush_count", 0, cnt[0], 10);
        drive(4'hF, adds, 2, 1, 0);
        chk("flush_count", 0, cnt[0], 0);
        chk("flush_empty", 0, emp[0], 1);
        chk("flush_valid", 0, ov[0], 0);

        drive(4'hF, adds, 0, 0, 0);
        drive(4'h0, 0, 1, 0, 0);
        drive(4'hF, {STORE, NOP, ADD, NOP}, 1, 0, 0);
        drive(4'hF, adds, 2, 0, 1);
        chk("rst_mid_count", 0, cnt[0], 0);
        chk("rst_mid_pulse", 0, nd[0], 0);
        chk("rst_mid_valid", 0, ov[0], 0);
        chk("rst_mid_count", 1, cnt[1], 0);

        run_random(3600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uop_multi_queue.md
Name: uop_multi_queue

Overview:
- Parametrised multi-lane circular FIFO for decoded micro-ops.
- Sits between decode and rename/ROB allocation.
- Accepts up to IN_W uops per cycle and presents up to OUT_W oldest uops per cycle.
- Supports partial dequeue, full flush on mispredict, and optional in-queue compaction that drops UOP_NOP lanes.
- Generalises the fixed INSTR_Q_DEPTH / INSTR_Q_WIDTH queue to independent input and output widths, plus NOP filtering.

Parameters:
- DEPTH, 32 (uop_pkg::INSTR_Q_DEPTH): entries; must be a power of 2, at least 2*max(IN_W,OUT_W).
- IN_W, 4 (uop_pkg::INSTR_Q_WIDTH): enqueue lanes per cycle.
- OUT_W, 4 (uop_pkg::INSTR_Q_WIDTH): dequeue lanes per cycle.
- DROP_NOP, 1: 1 = lanes whose uopcode==UOP_NOP are discarded at enqueue and surviving lanes are compacted in order; 0 = stored as-is.
- UOP_BITS, $bits(uop_pkg::uop_insn) (79): payload width per lane.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all contents this edge.
- in_valid  in  IN_W  per-lane valid; lane 0 is oldest; any mask legal.
- in_uop  in  IN_W*UOP_BITS  lane i at bits [i*UOP_BITS +: UOP_BITS], type uop_insn.
- in_ready  out  1  1 when free slots >= IN_W.
- out_valid  out  OUT_W  thermometer mask; lane j valid iff j < min(count, OUT_W).
- out_uop  out  OUT_W*UOP_BITS  lane j = entry at head+j (mod DEPTH); oldest in lane 0.
- out_pop  in  $clog2(OUT_W+1)  number of lanes consumed this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count==0.
- nop_dropped  out  1  pulse, registered: at least one NOP lane was discarded on the previous accepted enqueue.

Behaviour:
- State: head ptr, tail ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count register, storage array DEPTH x UOP_BITS. No separate FSM; occupancy states are EMPTY (count 0), PARTIAL, and NOSPACE (free < IN_W).
- Reset (rst=1 at edge): head=tail=count=0, nop_dropped=0. Storage contents are don't-care. Outputs then read in_ready=1, out_valid=0, empty=1. Reset mid-stream discards everything; reset has priority over flush, enqueue and pop.
- in_ready is combinational from the registered count only: in_ready = (DEPTH - count >= IN_W). It does not depend on same-cycle pop.
- Enqueue fires when in_ready && |in_valid.
  - Kept lanes = valid lanes, minus NOP lanes when DROP_NOP=1.
  - Kept lanes are written in lane order to tail, tail+1, … (wrapping); tail advances by the number kept.
  - Gaps in in_valid are compacted; lane order is preserved.
- in_valid while !in_ready: ignored, no state change. The producer must hold its data.
- Dequeue: effective pop = min(out_pop, popcount(out_valid)). Popping more than the valid lanes is clamped; an assertion fires in simulation. head advances by the effective pop.
- Simultaneous enqueue and dequeue: both apply at the same edge; count_next = count + kept - pop. Uops enqueued at edge N are visible on out_* at cycle N+1 at the earliest (1-cycle latency, no bypass), even when the queue is empty.
- Flush (not rst): head=tail=count=0 at the edge. Enqueue and pop in the same cycle are discarded; nop_dropped=0.
- nop_dropped is registered: 1 for the cycle after an accepted enqueue in which one or more valid NOP lanes were discarded, else 0. It is always 0 when DROP_NOP=0.
- Wrap-around: pointer arithmetic is modulo DEPTH. count disambiguates full vs. empty. count never exceeds DEPTH (guaranteed by in_ready).
- out_uop lanes beyond the out_valid range are don't-care but must not contain X after reset in gate-level simulation; zeros are acceptable.

Test Plan:
- Reset, then IN_W=4 valid ADD/SUB/AND/ORR on lanes 0–3 in one cycle, out_pop=0 → next cycle count=4, out_valid=4'b1111, lane order ADD, SUB, AND, ORR; in_ready=1.
- Fill to 29 entries (DEPTH=32) → in_ready=0. Present 4 lanes → ignored, count stays 29. Pop 1 → count 28; in_ready=1 in the following cycle.
- DROP_NOP=1, in_valid=4'b1111 with lanes {NOP, ADD, NOP, STORE} → count +2; stored order ADD then STORE; nop_dropped=1 one cycle later. Same stimulus with DROP_NOP=0 → count +4, nop_dropped=0.
- Wrap: drive head=tail=30 via 30 enq/pop cycles, then enqueue 4 → entries land at indices 30, 31, 0, 1; out_uop lanes 0–3 show them in order.
- Simultaneous: count=6, enqueue 3 valid (in_valid=4'b0111) with out_pop=2 → count=7 next cycle. With out_pop=4 while count=2 → effective pop 2, count=0+kept, assertion flagged.
- Flush with count=10 plus concurrent enqueue of 4 and pop of 2 → count=0, empty=1, out_valid=0 next cycle. rst asserted mid-burst of alternating enq/pop → same result, nop_dropped=0.
